alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Two-requester front end for the 16-bit ALU (adder/sub/mul/or/and/xor/shift/rotate + result mux).
//  Round-robin arbitrates requesters, drives operands/select, pulses the mux 'execute' strobe,
//  captures result and NCZV flags, and returns them on a valid/ready response channel.
//  Sits between the instruction issue stage (req0) and the address-gen unit (req1) and the ALU.
// PARAMETERS
//  WIDTH    16  operand/result width; must match the ALU
//  MUL_LAT  2   extra wait cycles for op 2 (MUL); used only when ALU_SEQ_MUL_STALL_EN is defined
// PORTS
//  clk          in   1      single clock; all state changes on its rising edge
//  rst_n        in   1      synchronous, active-low reset
//  reqN_valid   in   1      N=0,1: request pending
//  reqN_ready   out  1      N=0,1: request accepted this cycle (valid&&ready)
//  reqN_op      in   4      ALU select: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 LSL, 7 LSR, 8 ROR
//  reqN_a       in   WIDTH  operand 1
//  reqN_b       in   WIDTH  operand 2; b[3:0] is also the shift amount
//  resp_valid   out  1      response available
//  resp_ready   in   1      response consumed
//  resp_id      out  1      requester that issued the response
//  resp_result  out  WIDTH  ALU result
//  resp_flags   out  4      {V,Z,C,N} = ALU f[3:0]
//  resp_err     out  1      illegal opcode (op > 8)
//  alu_in1      out  WIDTH  to ALU in1
//  alu_in2      out  WIDTH  to ALU in2
//  alu_shiftb   out  4      to ALU shift amount (= latched b[3:0])
//  alu_sel      out  4      to ALU mux sel and flag-mux sel2
//  alu_execute  out  1      mux strobe; exactly one clk cycle high per legal op
//  alu_result   in   WIDTH  mux output
//  alu_flags    in   4      flag-mux output
//  flags_q      out  4      architectural flag register, last legal completion
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst_n low at clk edge): state IDLE, every output 0, rr pointer favours req0, any
//   in-flight op dropped (no response issued). Same effect mid-operation, in any state.
//  FSM: IDLE -> ISSUE -> STROBE -> [MULWAIT] -> RESP -> IDLE.
//   IDLE: if any valid, assert ready to the granted requester for one cycle; latch op/a/b/id.
//   ISSUE: alu_in1/in2/shiftb/sel driven from latched values (held stable through STROBE/MULWAIT);
//    alu_execute=0. Illegal op: skip straight to RESP with err=1, result=0, flags=0.
//   STROBE: alu_execute=1 for this one cycle; alu_result/alu_flags sampled at the edge leaving STROBE.
//   RESP: resp_valid=1, payload stable until resp_valid&&resp_ready; then IDLE.
//  Latency: acceptance edge T -> resp_valid high from T+3 (legal, no stall); T+2 for illegal op.
//  Throughput: one op per 4 cycles min; no new acceptance while busy; ready=0 outside IDLE.
//  Arbitration: one valid -> grant it; both valid -> grant the one not granted last; pointer
//   updates only on acceptance.
//  flags_q: loads sampled alu_flags on entry to RESP for legal ops only; illegal op leaves it.
//  Backpressure: resp_ready low holds RESP indefinitely; alu_execute stays 0.
//  Requester must hold op/a/b stable while valid && !ready (standard valid/ready).
// CONFIGURATION
//  ALU_SEQ_MUL_STALL_EN defined: op 2 goes STROBE -> MULWAIT for MUL_LAT cycles, sampling at the
//   edge leaving MULWAIT; MUL latency T+3+MUL_LAT. alu_execute is not re-pulsed.
//  Not defined: MULWAIT state absent; MUL timed like every other op; MUL_LAT ignored.
// TESTING
//  1 req0 ADD a=0x0003 b=0x0004 -> ready at T, alu_sel=0, execute high only in T+2 cycle,
//    resp_valid at T+3, result=0x0007, flags=4'b0000, resp_id=0, flags_q=0.
//  2 After reset, req0 and req1 both valid (XOR, OR) -> req0 served first, then req1; next
//    simultaneous pair -> req0 again (pointer last=1).
//  3 req1 op=4'hA -> no execute pulse, resp_valid at T+2, resp_err=1, result=0, flags_q unchanged.
//  4 resp_ready low 5 cycles during RESP -> payload stable, both ready=0, busy=1, no execute.
//  5 rst_n low for one edge during STROBE -> next cycle IDLE, resp_valid=0, alu_execute=0,
//    busy=0; pending response never appears.
//  6 With ALU_SEQ_MUL_STALL_EN, MUL_LAT=2: MUL 0x0010*0x0003 -> resp_valid at T+5,
//    result=0x0030; without the macro -> T+3, same result.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Two-requester round-robin front end for the 16-bit ALU: issues one op, strobes the result mux,
// captures result/NCZV flags and returns them on a valid/ready channel. Optional: ALU_SEQ_MUL_STALL_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_shiftb,
  output logic [3:0]       alu_sel,
  output logic             alu_execute,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       flags_q,
  output logic             busy
);

  if (WIDTH < 4 || MUL_LAT > 255) begin : g_param_check
    $error("alu_op_sequencer: WIDTH must be >= 4 and MUL_LAT <= 255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STROBE,
`ifdef ALU_SEQ_MUL_STALL_EN
    S_MULWAIT,
`endif
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       rflags_q, rflags_d;
  logic             err_q, err_d;
  logic [3:0]       flags_d;
  logic             gnt1;
  logic             capture;
`ifdef ALU_SEQ_MUL_STALL_EN
  logic [7:0]       wait_q, wait_d;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    rflags_d    = rflags_q;
    err_d       = err_q;
    flags_d     = flags_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    alu_execute = 1'b0;
    capture     = 1'b0;
    // last_q == 1 means req1 won the previous grant, so req0 wins a tie
    gnt1        = req1_valid && (!req0_valid || !last_q);
`ifdef ALU_SEQ_MUL_STALL_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = !gnt1;
          req1_ready = gnt1;
          id_d       = gnt1;
          last_d     = gnt1;
          op_d       = gnt1 ? req1_op : req0_op;
          a_d        = gnt1 ? req1_a  : req0_a;
          b_d        = gnt1 ? req1_b  : req0_b;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_q > 4'd8) begin
          err_d    = 1'b1;
          result_d = '0;
          rflags_d = '0;
          state_d  = S_RESP;
        end else begin
          err_d   = 1'b0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        alu_execute = 1'b1;
        capture     = 1'b1;
`ifdef ALU_SEQ_MUL_STALL_EN
        if (op_q == 4'd2 && MUL_LAT != 0) begin
          capture = 1'b0;
          wait_d  = 8'(MUL_LAT - 1);
          state_d = S_MULWAIT;
        end
      end
      S_MULWAIT: begin
        if (wait_q == '0) capture = 1'b1;
        else              wait_d  = wait_q - 8'd1;
`endif
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // legal ops only: sample the mux and load the architectural flags on entry to RESP
    if (capture) begin
      result_d = alu_result;
      rflags_d = alu_flags;
      flags_d  = alu_flags;
      state_d  = S_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      rflags_q <= '0;
      err_q    <= 1'b0;
      flags_q  <= '0;
`ifdef ALU_SEQ_MUL_STALL_EN
      wait_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
`ifdef ALU_SEQ_MUL_STALL_EN
      wait_q   <= wait_d;
`endif
    end
  end

  assign resp_valid  = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_flags  = rflags_q;
  assign resp_err    = err_q;
  assign alu_in1     = a_q;
  assign alu_in2     = b_q;
  assign alu_shiftb  = b_q[3:0];
  assign alu_sel     = op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU plus a transaction-level model of arbitration,
// latency, response payload and flag register; directed cases followed by random traffic.
module tb_alu_op_sequencer;
  localparam int unsigned W    = 16;
  localparam int unsigned MLAT = 2;
`ifdef ALU_SEQ_MUL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp_valid, resp_ready, resp_id, resp_err;
  logic [W-1:0] resp_result;
  logic [3:0]   resp_flags;
  logic [W-1:0] alu_in1, alu_in2, alu_result;
  logic [3:0]   alu_shiftb, alu_sel, alu_flags, flags_q;
  logic         alu_execute, busy;

  alu_op_sequencer #(.WIDTH(W), .MUL_LAT(MLAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shiftb(alu_shiftb), .alu_sel(alu_sel),
    .alu_execute(alu_execute), .alu_result(alu_result), .alu_flags(alu_flags),
    .flags_q(flags_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Returns {V,Z,C,N, result}
  function automatic logic [19:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, v;
    int unsigned s;
    s = b[3:0]; c = 1'b0; v = 1'b0; r = '0; w = '0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16]; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a * b;
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: r = a ^ b;
      4'd6: r = a << s;
      4'd7: r = a >> s;
      4'd8: r = (a >> s) | (a << (16 - s));
      default: r = 16'hBAD0;
    endcase
    return {v, (r == 16'h0), c, r[15], r};
  endfunction

  // ALU stand-in: live output while strobed, holds the strobed value otherwise
  logic [19:0] alu_now;
  logic [19:0] alu_hold = 20'h0;
  always_comb alu_now = alu_ref(alu_sel, alu_in1, {alu_in2[15:4], alu_shiftb});
  always @(posedge clk) if (alu_execute) alu_hold <= alu_now;
  assign {alu_flags, alu_result} = alu_execute ? alu_now : alu_hold;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rst_at   = -1;
  int rdy_pct  = 100;
  bit gen_en   = 1'b0;

  bit          pending [2];
  logic [3:0]  r_op [2];
  logic [15:0] r_a [2];
  logic [15:0] r_b [2];
  bit          last = 1'b1;
  bit          outst = 1'b0;
  bit          acc_pending = 1'b0;
  bit          acc_g;
  int          t_acc, t_due;
  bit          m_id, m_legal;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b;
  logic [19:0] m_exp;
  logic [3:0]  m_flags = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic put_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    pending[i] = 1'b1; r_op[i] = op; r_a[i] = a; r_b[i] = b;
  endtask

  task automatic new_req(input int i);
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
    if ($urandom_range(0, 7) == 0) b = 16'h8000;
    put_req(i, 4'($urandom_range(0, 11)), a, b);
  endtask

  task automatic step();
    bit e0, e1, g;
    @(posedge clk);
    cyc++;
    #1;
    if (acc_pending) begin pending[acc_g] = 1'b0; acc_pending = 1'b0; end
    if (gen_en)
      for (int i = 0; i < 2; i++)
        if (!pending[i] && $urandom_range(0, 2) == 0) new_req(i);
    req0_valid = pending[0]; req0_op = r_op[0]; req0_a = r_a[0]; req0_b = r_b[0];
    req1_valid = pending[1]; req1_op = r_op[1]; req1_a = r_a[1]; req1_b = r_b[1];
    resp_ready = ($urandom_range(0, 99) < rdy_pct);
    rst_n      = (cyc != rst_at);
    @(negedge clk);

    e0 = 1'b0; e1 = 1'b0; g = 1'b0;
    if (!outst && (pending[0] || pending[1])) begin
      if (pending[0] && pending[1]) g = ~last;
      else                          g = pending[1];
      e0 = !g; e1 = g;
    end
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("busy", busy, outst);
    check("alu_execute", alu_execute, outst && m_legal && (cyc == t_acc + 2));
    check("resp_valid", resp_valid, outst && (cyc >= t_due));
    if (outst && cyc > t_acc && cyc < t_due) begin
      check("alu_sel", alu_sel, m_op);
      check("alu_in1", alu_in1, m_a);
      check("alu_in2", alu_in2, m_b);
      check("alu_shiftb", alu_shiftb, m_b[3:0]);
    end
    if (outst && m_legal && cyc == t_due) m_flags = m_exp[19:16];
    check("flags_q", flags_q, m_flags);
    if (outst && cyc >= t_due) begin
      check("resp_id", resp_id, m_id);
      check("resp_result", resp_result, m_legal ? m_exp[15:0] : 16'h0);
      check("resp_flags", resp_flags, m_legal ? m_exp[19:16] : 4'h0);
      check("resp_err", resp_err, !m_legal);
      if (resp_ready) outst = 1'b0;
    end

    if (!rst_n) begin
      outst = 1'b0; last = 1'b1; m_flags = 4'h0; e0 = 1'b0; e1 = 1'b0;
    end
    if (e0 || e1) begin
      outst   = 1'b1;
      t_acc   = cyc;
      m_id    = e1;
      m_op    = r_op[e1];
      m_a     = r_a[e1];
      m_b     = r_b[e1];
      m_legal = (m_op <= 4'd8);
      m_exp   = alu_ref(m_op, m_a, m_b);
      t_due   = cyc + (!m_legal ? 2 : ((STALL && m_op == 4'd2) ? 3 + int'(MLAT) : 3));
      last    = e1;
      acc_pending = 1'b1;
      acc_g   = e1;
    end
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    pending[0] = 1'b0; pending[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_execute", alu_execute, 1'b0);
    check("rst_flags_q", flags_q, 4'h0);
    check("rst_result", resp_result, 16'h0);
    check("rst_err", resp_err, 1'b0);
    check("rst_alu_sel", alu_sel, 4'h0);
    check("rst_alu_in1", alu_in1, 16'h0);

    put_req(0, 4'd0, 16'h0003, 16'h0004);
    repeat (6) step();

    put_req(0, 4'd5, 16'h00F0, 16'h0FF0);
    put_req(1, 4'd3, 16'h1200, 16'h0034);
    repeat (12) step();
    put_req(0, 4'd4, 16'hF0F0, 16'h3C3C);
    put_req(1, 4'd1, 16'h0000, 16'h0001);
    repeat (12) step();

    put_req(1, 4'hA, 16'h1234, 16'h5678);
    repeat (5) step();

    put_req(0, 4'd8, 16'h8001, 16'h000F);
    rdy_pct = 0;
    repeat (9) step();
    rdy_pct = 100;
    repeat (3) step();

    put_req(0, 4'd0, 16'h7FFF, 16'h0001);
    rst_at = cyc + 3;
    repeat (6) step();

    put_req(0, 4'd2, 16'h0010, 16'h0003);
    repeat (8) step();
    put_req(1, 4'd6, 16'h8001, 16'h0000);
    repeat (5) step();
    put_req(1, 4'd7, 16'h8000, 16'h000F);
    repeat (5) step();

    gen_en  = 1'b1;
    rdy_pct = 70;
    repeat (3000) step();
    gen_en  = 1'b0;
    rdy_pct = 100;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
